// File: rtl/addsub_pipe_pkg.sv
// Shared definitions for the modular add/subtract butterfly stage.
package addsub_pipe_pkg;

  localparam int DATA_WIDTH_DEF = 12;
  localparam int Q_DEF          = 3329;
  localparam int LANES_DEF      = 2;

  // Mode travels with each beat; INTT additionally halves the result mod Q.
  typedef enum logic {
    MODE_NTT  = 1'b0,
    MODE_INTT = 1'b1
  } mode_e;

  typedef logic [DATA_WIDTH_DEF-1:0] coef_t;
  typedef coef_t lane_vec_t [LANES_DEF];

endpackage

// File: rtl/addsub_pipe_if.sv
// Beat-level handshake bus of the butterfly stage: input beat channel and
// result channel. The master drives operands and consumes results.
interface addsub_pipe_if
  import addsub_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int LANES      = LANES_DEF
) ();

  logic                        in_valid;
  logic                        in_ready;
  logic                        in_mode;
  logic [LANES*DATA_WIDTH-1:0] in_a;
  logic [LANES*DATA_WIDTH-1:0] in_b;

  logic                        out_valid;
  logic                        out_ready;
  logic                        out_mode;
  logic [LANES*DATA_WIDTH-1:0] out_sum;
  logic [LANES*DATA_WIDTH-1:0] out_diff;

  modport master (
    output in_valid, in_mode, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_mode, out_sum, out_diff
  );

  modport slave (
    input  in_valid, in_mode, in_a, in_b, out_ready,
    output in_ready, out_valid, out_mode, out_sum, out_diff
  );

endinterface

// File: rtl/addsub_lane.sv
// Per-lane reduction of raw sum/difference to 0..Q-1, with optional halving
// mod Q (multiply by 2^-1) for INTT. Purely combinational.
module addsub_lane
  import addsub_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int Q          = Q_DEF
) (
  input  mode_e                  mode,
  input  logic [DATA_WIDTH:0]    s,
  input  logic signed [DATA_WIDTH:0] d,
  output logic [DATA_WIDTH-1:0]  sum,
  output logic [DATA_WIDTH-1:0]  diff
);

  // Two guard bits: adding Q to an odd value before halving may exceed 2^(W+1).
  localparam int W = DATA_WIDTH + 2;
  localparam logic [W-1:0] QW = W'(Q);

  logic [W-1:0] s_w, d_w, d_pos, s_odd, d_odd, s_half, d_half, s_red, d_red;

  // Both reductions are built in parallel; mode only picks the final result.
  // Halving works because Q is odd: x odd -> x+Q even and congruent mod Q.
  always_comb begin
    s_w    = {1'b0, s};
    d_w    = {d[DATA_WIDTH], d};
    d_pos  = d[DATA_WIDTH] ? d_w + QW : d_w;
    s_odd  = s_w[0] ? s_w + QW : s_w;
    d_odd  = d_pos[0] ? d_pos + QW : d_pos;
    s_half = s_odd >> 1;
    d_half = d_odd >> 1;
    if (mode == MODE_INTT) begin
      s_red = (s_half >= QW) ? s_half - QW : s_half;
      d_red = d_half;
    end else begin
      s_red = (s_w >= QW) ? s_w - QW : s_w;
      d_red = d_pos;
    end
    sum  = s_red[DATA_WIDTH-1:0];
    diff = d_red[DATA_WIDTH-1:0];
  end

endmodule

// File: rtl/addsub_pipe.sv
// Multi-lane modular add/subtract butterfly stage with a 2-deep valid/ready
// pipeline: stage 1 holds raw a+b / a-b, stage 2 holds reduced results.
module addsub_pipe
  import addsub_pipe_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int Q          = Q_DEF,
  parameter int LANES      = LANES_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               flush,
  addsub_pipe_if.slave       bus
);

  logic                         en1, en2;
  logic                         s1_valid;
  mode_e                        s1_mode;
  logic [DATA_WIDTH:0]          s1_s [LANES];
  logic signed [DATA_WIDTH:0]   s1_d [LANES];

  logic [DATA_WIDTH-1:0]        a_l   [LANES];
  logic [DATA_WIDTH-1:0]        b_l   [LANES];
  logic [DATA_WIDTH-1:0]        red_s [LANES];
  logic [DATA_WIDTH-1:0]        red_d [LANES];

  logic                         out_valid_q;
  logic                         out_mode_q;
  logic [LANES*DATA_WIDTH-1:0]  out_sum_q, out_diff_q;

  // Stall propagates backwards; in_ready depends only on state and out_ready.
  assign en2          = !out_valid_q || bus.out_ready;
  assign en1          = !s1_valid || en2;
  assign bus.in_ready = en1;

  assign bus.out_valid = out_valid_q;
  assign bus.out_mode  = out_mode_q;
  assign bus.out_sum   = out_sum_q;
  assign bus.out_diff  = out_diff_q;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign a_l[i] = bus.in_a[i*DATA_WIDTH +: DATA_WIDTH];
    assign b_l[i] = bus.in_b[i*DATA_WIDTH +: DATA_WIDTH];

    addsub_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .Q          (Q)
    ) u_lane (
      .mode (s1_mode),
      .s    (s1_s[i]),
      .d    (s1_d[i]),
      .sum  (red_s[i]),
      .diff (red_d[i])
    );
  end

  // Stage 1: capture raw sum and signed difference of an accepted beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_mode  <= MODE_NTT;
      for (int i = 0; i < LANES; i++) begin
        s1_s[i] <= '0;
        s1_d[i] <= '0;
      end
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (en1) begin
      s1_valid <= bus.in_valid;
      if (bus.in_valid) begin
        s1_mode <= mode_e'(bus.in_mode);
        for (int i = 0; i < LANES; i++) begin
          s1_s[i] <= {1'b0, a_l[i]} + {1'b0, b_l[i]};
          s1_d[i] <= signed'({1'b0, a_l[i]}) - signed'({1'b0, b_l[i]});
        end
      end
    end
  end

  // Stage 2: register reduced results; held stable while downstream stalls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_mode_q  <= 1'b0;
      out_sum_q   <= '0;
      out_diff_q  <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (en2) begin
      out_valid_q <= s1_valid;
      if (s1_valid) begin
        out_mode_q <= s1_mode;
        for (int i = 0; i < LANES; i++) begin
          out_sum_q[i*DATA_WIDTH +: DATA_WIDTH]  <= red_s[i];
          out_diff_q[i*DATA_WIDTH +: DATA_WIDTH] <= red_d[i];
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_pipe.sv
// Self-checking bench for addsub_pipe: directed vector table, handshake
// corner sequences, and a randomized stream against a modular-arithmetic model.
module tb_addsub_pipe;
  import addsub_pipe_pkg::*;

  localparam int DW   = 12;
  localparam int QM   = 3329;
  localparam int L    = 2;
  localparam int INV2 = (QM + 1) / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;

  addsub_pipe_if #(.DATA_WIDTH(DW), .LANES(L)) bus ();

  addsub_pipe #(.DATA_WIDTH(DW), .Q(QM), .LANES(L)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit mode;
    int a[L];
    int b[L];
    int sum[L];
    int diff[L];
  } vec_t;

  typedef struct {
    bit mode;
    int sum[L];
    int diff[L];
  } exp_t;

  int     checks = 0;
  int     errors = 0;
  exp_t   q[$];
  exp_t   cur_exp;
  bit     acc;
  bit     stall_prev;
  logic   [L*DW-1:0] held_sum, held_diff;
  logic   held_mode;
  int     n_out;
  vec_t   tbl[4];

  // Reference: plain modular arithmetic, halving as multiplication by 2^-1 mod Q.
  function automatic int ref_sum(bit m, int a, int b);
    int r = (a + b) % QM;
    return m ? (r * INV2) % QM : r;
  endfunction

  function automatic int ref_diff(bit m, int a, int b);
    int r = (a - b + QM) % QM;
    return m ? (r * INV2) % QM : r;
  endfunction

  function automatic vec_t mkv(bit m, int a0, int b0, int a1, int b1,
                               int s0, int d0, int s1, int d1);
    vec_t v;
    v.mode = m;
    v.a[0] = a0; v.b[0] = b0; v.a[1] = a1; v.b[1] = b1;
    v.sum[0] = s0; v.diff[0] = d0; v.sum[1] = s1; v.diff[1] = d1;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic set_beat(input bit m, input int a0, input int b0, input int a1, input int b1);
    int a[L];
    int b[L];
    a[0] = a0; a[1] = a1; b[0] = b0; b[1] = b1;
    bus.in_mode = m;
    cur_exp.mode = m;
    for (int i = 0; i < L; i++) begin
      bus.in_a[i*DW +: DW] = DW'(a[i]);
      bus.in_b[i*DW +: DW] = DW'(b[i]);
      cur_exp.sum[i]  = ref_sum(m, a[i], b[i]);
      cur_exp.diff[i] = ref_diff(m, a[i], b[i]);
    end
  endtask

  task automatic set_rand_beat(input bit m);
    set_beat(m, $urandom_range(QM-1), $urandom_range(QM-1),
                $urandom_range(QM-1), $urandom_range(QM-1));
  endtask

  // One clock of scoreboard bookkeeping; call just after the falling edge
  // with inputs already driven for the coming rising edge.
  task automatic cycle();
    exp_t e;
    #1;
    acc = 1'b0;
    if (flush) begin
      q.delete();
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        chk("hold_valid", 32'(bus.out_valid), 32'd1);
        chk("hold_sum",   32'(bus.out_sum),   32'(held_sum));
        chk("hold_diff",  32'(bus.out_diff),  32'(held_diff));
        chk("hold_mode",  32'(bus.out_mode),  32'(held_mode));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_out_beat", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          n_out++;
          chk("sb_mode", 32'(bus.out_mode), 32'(e.mode));
          for (int i = 0; i < L; i++) begin
            chk($sformatf("sb_sum_l%0d", i),  32'(bus.out_sum[i*DW +: DW]),  32'(e.sum[i]));
            chk($sformatf("sb_diff_l%0d", i), 32'(bus.out_diff[i*DW +: DW]), 32'(e.diff[i]));
          end
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        q.push_back(cur_exp);
        acc = 1'b1;
      end
      stall_prev = bus.out_valid && !bus.out_ready;
      held_sum   = bus.out_sum;
      held_diff  = bus.out_diff;
      held_mode  = bus.out_mode;
    end
    @(negedge clk);
  endtask

  task automatic drain(input string nm);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 20 && q.size() > 0; t++) cycle();
    chk(nm, 32'(q.size()), 32'd0);
  endtask

  // Single beat with exact 2-cycle latency and table-given results.
  task automatic apply_vec(input vec_t v, input string nm);
    set_beat(v.mode, v.a[0], v.b[0], v.a[1], v.b[1]);
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b1;
    #1 chk({nm, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1 chk({nm, "_lat1_valid"}, 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    #1;
    chk({nm, "_lat2_valid"}, 32'(bus.out_valid), 32'd1);
    chk({nm, "_mode"}, 32'(bus.out_mode), 32'(v.mode));
    for (int i = 0; i < L; i++) begin
      chk($sformatf("%s_sum_l%0d", nm, i),  32'(bus.out_sum[i*DW +: DW]),  32'(v.sum[i]));
      chk($sformatf("%s_diff_l%0d", nm, i), 32'(bus.out_diff[i*DW +: DW]), 32'(v.diff[i]));
    end
    @(negedge clk);
  endtask

  task automatic no_stale(input string nm);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 4; t++) begin
      #1 chk(nm, 32'(bus.out_valid), 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int  sent;
    bit  dropchk;

    tbl[0] = mkv(1'b0, 3000, 500, 100, 200,   171, 2500, 300, 3229);
    tbl[1] = mkv(1'b1, 3, 0, 0, 1,            1666, 1666, 1665, 1664);
    tbl[2] = mkv(1'b0, QM-1, QM-1, 0, QM-1,   3327, 0, 3328, 1);
    tbl[3] = mkv(1'b1, QM-1, QM-1, 0, 0,      3328, 0, 0, 0);

    bus.in_valid  = 1'b0;
    bus.in_mode   = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;
    stall_prev    = 1'b0;
    n_out         = 0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_sum",   32'(bus.out_sum),   32'd0);
    chk("rst_out_diff",  32'(bus.out_diff),  32'd0);
    chk("rst_out_mode",  32'(bus.out_mode),  32'd0);
    rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    @(negedge clk);

    // Directed vector table
    for (int k = 0; k < 4; k++) apply_vec(tbl[k], $sformatf("vec%0d", k));

    // Alternating modes, back-to-back, no stall
    n_out = 0;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      set_rand_beat(k[0]);
      bus.in_valid = 1'b1;
      #1 chk("alt_in_ready", 32'(bus.in_ready), 32'd1);
      cycle();
    end
    drain("alt_drain");
    chk("alt_count", 32'(n_out), 32'd20);

    // Backpressure: 5 beats, output stalled for 4 cycles
    n_out = 0; sent = 0; dropchk = 1'b0;
    bus.out_ready = 1'b0;
    set_rand_beat(1'b0);
    bus.in_valid = 1'b1;
    for (int t = 0; t < 40 && !(sent == 5 && q.size() == 0); t++) begin
      bus.out_ready = (t >= 6);
      if (sent == 2 && !bus.out_ready && !dropchk) begin
        #1 chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
        dropchk = 1'b1;
      end
      cycle();
      if (acc) begin
        sent++;
        if (sent < 5) set_rand_beat(sent[0]);
        else bus.in_valid = 1'b0;
      end
    end
    chk("bp_sent", 32'(sent), 32'd5);
    chk("bp_count", 32'(n_out), 32'd5);
    chk("bp_dropchk_reached", 32'(dropchk), 32'd1);
    drain("bp_drain");

    // Reset mid-stream with 2 beats in flight
    bus.out_ready = 1'b0;
    set_rand_beat(1'b0); bus.in_valid = 1'b1; cycle();
    set_rand_beat(1'b1); cycle();
    bus.in_valid = 1'b0;
    #1 chk("rstm_pre_valid", 32'(bus.out_valid), 32'd1);
    rst_n = 1'b0;
    #1 chk("rstm_valid_now", 32'(bus.out_valid), 32'd0);
    q.delete();
    stall_prev = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    no_stale("rstm_no_stale");
    apply_vec(tbl[0], "rstm_next");

    // Flush with 2 beats in flight plus one presented in the flush cycle
    bus.out_ready = 1'b0;
    set_rand_beat(1'b1); bus.in_valid = 1'b1; cycle();
    set_rand_beat(1'b0); cycle();
    set_rand_beat(1'b0);
    flush = 1'b1;
    bus.out_ready = 1'b1;
    cycle();
    flush = 1'b0;
    bus.in_valid = 1'b0;
    #1 chk("flush_valid", 32'(bus.out_valid), 32'd0);
    no_stale("flush_no_stale");
    apply_vec(tbl[1], "flush_next");

    // Randomized stream with random backpressure and occasional flush
    for (int t = 0; t < 400; t++) begin
      if (!bus.in_valid || acc) begin
        set_rand_beat(1'($urandom_range(1)));
        bus.in_valid = 1'($urandom_range(1));
      end
      bus.out_ready = ($urandom_range(9) < 7);
      flush = ($urandom_range(49) == 0);
      cycle();
    end
    flush = 1'b0;
    drain("rand_drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
